// File: rtl/voice_mix_sched.sv
// Time-multiplexed phase-accumulator voice mixer: one frame per strobe walks every
// voice through a phase-update slot and a shared-LUT lookup slot, then emits the mix.
module voice_mix_sched #(
   parameter int unsigned NUM_VOICES = 4,
   parameter int unsigned RAMP_MAX   = 60000
) (
   input  logic                      iCLK_18_4,
   input  logic                      iRST_N,
   input  logic                      iFrame_Strobe,
   input  logic [NUM_VOICES-1:0]     iKey_On,
   input  logic [16*NUM_VOICES-1:0]  iStep,
   output logic [5:0]                oLut_Addr,
   input  logic [15:0]               iLut_Data,
   output logic [15:0]               oSample,
   output logic                      oSample_Valid,
   output logic                      oBusy,
   output logic                      oOverrun,
   output logic [2:0]                oActive
);

   localparam int unsigned   VW       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [VW-1:0] LAST_V   = VW'(NUM_VOICES - 1);
   localparam logic [15:0]   RAMP_LIM = 16'(RAMP_MAX);

   typedef enum logic [1:0] {IDLE, PH, LK, OUT} state_t;

   state_t        state;
   logic [VW-1:0] vidx;
   logic [17:0]   acc;
   logic [15:0]   phase_q [NUM_VOICES];
   logic [15:0]   phase_cur;
   logic [15:0]   step_cur;
   logic [15:0]   phase_nxt;
   logic [2:0]    active_cnt;

   // Phase update for the voice in its PH slot; a gated-off voice is parked at zero.
   always_comb begin
      phase_cur = phase_q[vidx];
      step_cur  = iStep[16*vidx +: 16];
      if (!iKey_On[vidx])
         phase_nxt = '0;
      else if (phase_cur > RAMP_LIM)
         phase_nxt = '0;
      else
         phase_nxt = phase_cur + step_cur;
   end

   always_comb begin
      active_cnt = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++)
         active_cnt = active_cnt + 3'(iKey_On[i]);
   end

   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         state         <= IDLE;
         vidx          <= '0;
         acc           <= '0;
         oLut_Addr     <= '0;
         oSample       <= '0;
         oSample_Valid <= 1'b0;
         oBusy         <= 1'b0;
         oOverrun      <= 1'b0;
         oActive       <= '0;
         for (int unsigned i = 0; i < NUM_VOICES; i++)
            phase_q[i] <= '0;
      end else begin
         oSample_Valid <= 1'b0;
         oOverrun      <= iFrame_Strobe && (state != IDLE);
         case (state)
            IDLE: begin
               if (iFrame_Strobe) begin
                  acc   <= '0;
                  vidx  <= '0;
                  oBusy <= 1'b1;
                  state <= PH;
               end
            end
            PH: begin
               phase_q[vidx] <= phase_nxt;
               oLut_Addr     <= phase_nxt[15:10];
               state         <= LK;
            end
            LK: begin
               if (iKey_On[vidx])
                  acc <= acc + {{2{iLut_Data[15]}}, iLut_Data};
               oLut_Addr <= '0;
               if (vidx == LAST_V) begin
                  state <= OUT;
               end else begin
                  vidx  <= vidx + 1'b1;
                  state <= PH;
               end
            end
            OUT: begin
               oSample       <= acc[17:2];
               oSample_Valid <= 1'b1;
               oActive       <= active_cnt;
               oBusy         <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_mix_sched.sv
// Scoreboard bench for voice_mix_sched: expected mixes are queued per strobe and
// checked by a monitor on every oSample_Valid pulse.
module tb_voice_mix_sched;

   logic        iCLK_18_4 = 1'b0;
   logic        iRST_N;
   logic        iFrame_Strobe;
   logic [3:0]  iKey_On;
   logic [63:0] iStep;
   logic [5:0]  oLut_Addr;
   logic [15:0] iLut_Data;
   logic [15:0] oSample;
   logic        oSample_Valid;
   logic        oBusy;
   logic        oOverrun;
   logic [2:0]  oActive;

   logic        lut_mode;
   logic [15:0] lut_const;

   typedef struct {
      logic [15:0] sample;
      logic [2:0]  active;
   } exp_t;

   exp_t       exp_q[$];
   int         tests = 0;
   int         fails = 0;
   int         valid_cnt = 0;
   logic [5:0] lk_addr [4];

   always #5 iCLK_18_4 = ~iCLK_18_4;

   // LUT model: addr*256, or a constant for full-scale tests
   always_comb iLut_Data = lut_mode ? lut_const : {2'b00, oLut_Addr, 8'h00};

   voice_mix_sched #(.NUM_VOICES(4), .RAMP_MAX(60000)) dut (
      .iCLK_18_4     (iCLK_18_4),
      .iRST_N        (iRST_N),
      .iFrame_Strobe (iFrame_Strobe),
      .iKey_On       (iKey_On),
      .iStep         (iStep),
      .oLut_Addr     (oLut_Addr),
      .iLut_Data     (iLut_Data),
      .oSample       (oSample),
      .oSample_Valid (oSample_Valid),
      .oBusy         (oBusy),
      .oOverrun      (oOverrun),
      .oActive       (oActive)
   );

   always @(negedge iCLK_18_4) begin : monitor
      exp_t e;
      if (oSample_Valid === 1'b1) begin
         valid_cnt++;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL spurious_valid: oSample=%h oActive=%0d, no frame expected", oSample, oActive);
         end else begin
            e = exp_q.pop_front();
            if (oSample !== e.sample || oActive !== e.active) begin
               fails++;
               $display("FAIL sample: got sample=%h active=%0d, expected sample=%h active=%0d",
                        oSample, oActive, e.sample, e.active);
            end
         end
      end
   end

   task automatic apply_reset();
      @(negedge iCLK_18_4);
      iFrame_Strobe = 1'b0;
      iRST_N = 1'b0;
      @(negedge iCLK_18_4);
      iRST_N = 1'b1;
   endtask

   // Queues the expected mix, strobes once, and reports the edge index of oSample_Valid.
   task automatic run_frame(input logic [15:0] es, input logic [2:0] ea, output int lat);
      exp_q.push_back('{es, ea});
      @(negedge iCLK_18_4);
      iFrame_Strobe = 1'b1;
      @(posedge iCLK_18_4); #1;
      iFrame_Strobe = 1'b0;
      lat = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge iCLK_18_4); #1;
         if (k <= 7 && (k % 2) == 1) lk_addr[(k-1)/2] = oLut_Addr;
         if (oSample_Valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      @(negedge iCLK_18_4); #1;
   endtask

   task automatic test_reset();
      iRST_N = 1'b0;
      iFrame_Strobe = 1'b0;
      iKey_On = '0;
      iStep = '0;
      lut_mode = 1'b0;
      lut_const = '0;
      repeat (3) @(posedge iCLK_18_4);
      #1;
      tests++;
      if (oSample !== 16'h0 || oLut_Addr !== 6'h0 || oActive !== 3'd0) begin
         fails++;
         $display("FAIL reset_data: sample=%h addr=%h active=%0d, expected all 0", oSample, oLut_Addr, oActive);
      end
      tests++;
      if (oSample_Valid !== 1'b0 || oBusy !== 1'b0 || oOverrun !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags: valid=%b busy=%b overrun=%b, expected 0 0 0", oSample_Valid, oBusy, oOverrun);
      end
      @(negedge iCLK_18_4);
      iRST_N = 1'b1;
      repeat (6) @(posedge iCLK_18_4);
      #1;
      tests++;
      if (oBusy !== 1'b0 || valid_cnt !== 0) begin
         fails++;
         $display("FAIL idle_after_reset: busy=%b valid_count=%0d, expected 0 0", oBusy, valid_cnt);
      end
   endtask

   task automatic test_single_voice();
      int lat;
      apply_reset();
      iKey_On = 4'b0001;
      iStep = {16'd0, 16'd0, 16'd0, 16'd1024};
      lut_mode = 1'b0;
      run_frame(16'd64, 3'd1, lat);
      tests++;
      if (lat !== 9) begin
         fails++;
         $display("FAIL single_latency: valid at edge %0d, expected 9", lat);
      end
      tests++;
      if (lk_addr[0] !== 6'd1) begin
         fails++;
         $display("FAIL single_lut_addr: addr=%0d, expected 1", lk_addr[0]);
      end
      tests++;
      if (dut.phase_q[0] !== 16'd1024) begin
         fails++;
         $display("FAIL single_phase: phase0=%0d, expected 1024", dut.phase_q[0]);
      end
   endtask

   task automatic test_phase_wrap();
      int          lat;
      logic [15:0] steps [5] = '{16'd30000, 16'd30000, 16'd30000, 16'd36536, 16'd30000};
      logic [15:0] ph    [5] = '{16'd30000, 16'd60000, 16'd24464, 16'd61000, 16'd0};
      apply_reset();
      iKey_On = 4'b0001;
      lut_mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         iStep = {48'd0, steps[i]};
         run_frame(16'({10'd0, ph[i][15:10]} * 16'd64), 3'd1, lat);
         tests++;
         if (dut.phase_q[0] !== ph[i] || lat !== 9) begin
            fails++;
            $display("FAIL wrap_frame%0d: phase0=%0d lat=%0d, expected phase0=%0d lat=9",
                     i, dut.phase_q[0], lat, ph[i]);
         end
      end
   endtask

   task automatic test_full_scale();
      int lat;
      apply_reset();
      iKey_On = 4'b1111;
      iStep = {16'd700, 16'd500, 16'd300, 16'd100};
      lut_mode = 1'b1;
      lut_const = 16'h7FFF;
      run_frame(16'h7FFF, 3'd4, lat);
      tests++;
      if (lat !== 9) begin
         fails++;
         $display("FAIL fullscale_pos_latency: edge %0d, expected 9", lat);
      end
      lut_const = 16'h8000;
      run_frame(16'h8000, 3'd4, lat);
      tests++;
      if (lat !== 9) begin
         fails++;
         $display("FAIL fullscale_neg_latency: edge %0d, expected 9", lat);
      end
      lut_mode = 1'b0;
   endtask

   task automatic test_overrun();
      int ov_cnt = 0, ov_edge = 0, v_cnt = 0, v_edge = 0, busy_mid = 0;
      apply_reset();
      iKey_On = 4'b0001;
      iStep = {48'd0, 16'd2048};
      lut_mode = 1'b0;
      exp_q.push_back('{16'd128, 3'd1});
      @(negedge iCLK_18_4);
      iFrame_Strobe = 1'b1;
      @(posedge iCLK_18_4); #1;
      iFrame_Strobe = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         if (k == 3) iFrame_Strobe = 1'b1;
         @(posedge iCLK_18_4); #1;
         iFrame_Strobe = 1'b0;
         if (oOverrun === 1'b1) begin ov_cnt++; ov_edge = k; end
         if (oSample_Valid === 1'b1) begin v_cnt++; v_edge = k; end
         if (k == 5) busy_mid = int'(oBusy);
      end
      tests++;
      if (ov_cnt !== 1 || ov_edge !== 3) begin
         fails++;
         $display("FAIL overrun_pulse: count=%0d edge=%0d, expected count=1 edge=3", ov_cnt, ov_edge);
      end
      tests++;
      if (v_cnt !== 1 || v_edge !== 9) begin
         fails++;
         $display("FAIL overrun_single_frame: valids=%0d edge=%0d, expected 1 at edge 9", v_cnt, v_edge);
      end
      tests++;
      if (busy_mid !== 1 || oBusy !== 1'b0) begin
         fails++;
         $display("FAIL overrun_busy: mid=%0d end=%b, expected 1 0", busy_mid, oBusy);
      end
   endtask

   task automatic test_voice_off();
      int lat;
      apply_reset();
      iKey_On = 4'b0111;
      iStep = {16'd0, 16'd4096, 16'd2048, 16'd1024};
      lut_mode = 1'b0;
      run_frame(16'd448, 3'd3, lat);
      tests++;
      if (dut.phase_q[2] !== 16'd4096 || lat !== 9) begin
         fails++;
         $display("FAIL voice_off_setup: phase2=%0d lat=%0d, expected 4096 9", dut.phase_q[2], lat);
      end
      iKey_On = 4'b1011;
      iStep = {16'd3072, 16'd4096, 16'd2048, 16'd1024};
      lut_mode = 1'b1;
      lut_const = 16'h1000;
      run_frame(16'h0C00, 3'd3, lat);
      tests++;
      if (dut.phase_q[2] !== 16'd0 || lk_addr[2] !== 6'd0) begin
         fails++;
         $display("FAIL voice_off_phase: phase2=%0d addr=%0d, expected 0 0", dut.phase_q[2], lk_addr[2]);
      end
      lut_mode = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      int lat;
      apply_reset();
      iKey_On = 4'b1111;
      iStep = {16'd4096, 16'd3072, 16'd2048, 16'd1024};
      lut_mode = 1'b0;
      @(negedge iCLK_18_4);
      iFrame_Strobe = 1'b1;
      @(posedge iCLK_18_4); #1;
      iFrame_Strobe = 1'b0;
      repeat (3) @(posedge iCLK_18_4);
      #1;
      tests++;
      if (oLut_Addr !== 6'd2 || oBusy !== 1'b1) begin
         fails++;
         $display("FAIL midframe_lk1: addr=%0d busy=%b, expected 2 1", oLut_Addr, oBusy);
      end
      iRST_N = 1'b0;
      #1;
      tests++;
      if (oLut_Addr !== 6'd0 || oBusy !== 1'b0 || oSample !== 16'h0 || oSample_Valid !== 1'b0 ||
          oOverrun !== 1'b0 || oActive !== 3'd0 || dut.phase_q[0] !== 16'd0) begin
         fails++;
         $display("FAIL midframe_async_reset: addr=%0d busy=%b sample=%h phase0=%0d, expected all 0",
                  oLut_Addr, oBusy, oSample, dut.phase_q[0]);
      end
      repeat (2) @(negedge iCLK_18_4);
      iRST_N = 1'b1;
      repeat (4) @(posedge iCLK_18_4);
      run_frame(16'd640, 3'd4, lat);
      tests++;
      if (lat !== 9 || dut.phase_q[3] !== 16'd4096) begin
         fails++;
         $display("FAIL midframe_clean_frame: lat=%0d phase3=%0d, expected 9 4096", lat, dut.phase_q[3]);
      end
   endtask

   initial begin
      test_reset();
      test_single_voice();
      test_phase_wrap();
      test_full_scale();
      test_overrun();
      test_voice_off();
      test_reset_mid_frame();
      repeat (4) @(posedge iCLK_18_4);
      tests++;
      if (exp_q.size() !== 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d expected samples never produced", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/voice_mix_sched.md
VOICE_MIX_SCHED -- requirements
Module: voice_mix_sched

Interface
REQ-001 SHALL have parameter NUM_VOICES, 4, number of time-multiplexed voices.
REQ-002 SHALL have parameter RAMP_MAX, 60000, phase-accumulator wrap threshold.
REQ-003 SHALL have port iCLK_18_4, input, 1, sole clock (18.432 MHz), all state on its rising edge.
REQ-004 SHALL have port iRST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port iFrame_Strobe, input, 1, one-cycle pulse per LRCK frame, synchronous to iCLK_18_4.
REQ-006 SHALL have port iKey_On, input, NUM_VOICES, per-voice gate; bit i enables voice i.
REQ-007 SHALL have port iStep, input, 16*NUM_VOICES, per-voice phase increment; voice i is bits [16i+15:16i].
REQ-008 SHALL have port oLut_Addr, output, 6, address to the shared combinational wave LUT.
REQ-009 SHALL have port iLut_Data, input, 16, signed two's-complement LUT output, valid in the same cycle as oLut_Addr.
REQ-010 SHALL have port oSample, output, 16, signed mixed sample for the serializer.
REQ-011 SHALL have port oSample_Valid, output, 1, one-cycle pulse when oSample updates.
REQ-012 SHALL have port oBusy, output, 1, high whenever the FSM is not in IDLE.
REQ-013 SHALL have port oOverrun, output, 1, one-cycle pulse when a strobe arrives while busy.
REQ-014 SHALL have port oActive, output, 3, count of gated-on voices latched at the last OUT.

Function
REQ-015 SHALL implement the FSM states IDLE, PH (phase update), LK (lookup/accumulate) and OUT.
REQ-016 SHALL, in IDLE with iFrame_Strobe=1, clear the 18-bit signed accumulator, set voice index to 0 and go to PH.
REQ-017 SHALL, in PH for voice i: set phase[i]=0 if iKey_On[i]=0; else set it to 0 if phase[i]>RAMP_MAX; else set phase[i]=phase[i]+step[i] modulo 2^16; then go to LK.
REQ-018 SHALL drive oLut_Addr=phase[i][15:10] during LK (the updated phase) and 0 in all other states.
REQ-019 SHALL, in LK, add sign-extended iLut_Data to the accumulator only if iKey_On[i]=1, then go to PH for voice i+1, or to OUT after voice NUM_VOICES-1.
REQ-020 SHALL, in OUT, register oSample=accumulator arithmetically shifted right by 2 (bits [17:2]), assert oSample_Valid for exactly that cycle, latch the oActive popcount of iKey_On, and return to IDLE.
REQ-021 SHALL pulse oSample_Valid on the (2*NUM_VOICES+1)th rising edge after the edge that sampled iFrame_Strobe (9th edge for 4 voices).
REQ-022 SHALL ignore iFrame_Strobe when not in IDLE (no queued frame) and pulse oOverrun in the following cycle.
REQ-023 SHALL hold oSample between frames and never saturate, given that 4 voices of 16 bits fit within 18 bits.
REQ-024 SHALL sample iKey_On and iStep only in a voice's own PH/LK slots; changes at other times take effect in the next frame.
REQ-025 SHALL not advance the phases of any voice in frames that have no strobe.

Reset
REQ-026 SHALL, while iRST_N=0 (including mid-frame), force state=IDLE, all phases=0, accumulator=0, oSample=0, oSample_Valid=0, oBusy=0, oOverrun=0, oActive=0 and oLut_Addr=0.
REQ-027 SHALL, after reset release, take no action until the first iFrame_Strobe and produce no spurious oSample_Valid.

Verification
REQ-028 SHALL cover: voice0 on, step 1024, LUT model data=addr*256, one strobe -> phase0=1024, oLut_Addr=1 in LK0, oSample=64, oActive=1.
REQ-029 SHALL cover: voice0 step 30000, three strobes -> phase0 = 30000, 60000, 24464 (60000 is not >RAMP_MAX, so it wraps mod 2^16); a fourth strobe after phase=61000 forced -> phase0=0.
REQ-030 SHALL cover: all 4 voices on, LUT constant 0x7FFF -> oSample=0x7FFF; LUT constant 0x8000 -> oSample=0x8000; oActive=4.
REQ-031 SHALL cover: a second strobe 3 cycles after the first -> single oSample_Valid at edge 9, oOverrun pulse, no second frame.
REQ-032 SHALL cover: voice2 off with nonzero phase -> phase2=0 after its PH slot and no contribution (sample equals the sum of the other voices >>2).
REQ-033 SHALL cover: iRST_N asserted during LK of voice 1 -> all outputs 0 asynchronously, oBusy=0, the next strobe runs a full clean frame.
